// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the arbiter.
// The arbiter uses the slave modport; the core and bus side use master.
interface cpu_mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic [31:0]       if_rdata;
   logic              if_valid;
   logic              if_err;

   logic              ls_req;
   logic              ls_we;
   logic [1:0]        ls_size;
   logic [ADDR_W-1:0] ls_addr;
   logic [31:0]       ls_wdata;
   logic              ls_gnt;
   logic [31:0]       ls_rdata;
   logic              ls_valid;
   logic              ls_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
             mem_rdata, mem_ack,
      output if_gnt, if_rdata, if_valid, if_err,
             ls_gnt, ls_rdata, ls_valid, ls_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
             mem_rdata, mem_ack,
      input  if_gnt, if_rdata, if_valid, if_err,
             ls_gnt, ls_rdata, ls_valid, ls_err,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction in flight, with alignment, lane steering and bus timeout.
module cpu_mem_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int TIMEOUT       = 255,
   parameter int LS_STREAK_MAX = 4
) (
   input logic              clk,
   input logic              rst,
   cpu_mem_arbiter_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(LS_STREAK_MAX + 1);
   localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
   localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK_MAX);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

   state_e            state_q;
   logic [TW-1:0]     tmo_q;
   logic [SW-1:0]     streak_q;
   logic              owner_ls_q;
   logic [1:0]        size_q;
   logic [1:0]        off_q;

   logic              if_gnt_q, if_valid_q, if_err_q;
   logic              ls_gnt_q, ls_valid_q, ls_err_q;
   logic [31:0]       if_rdata_q, ls_rdata_q;
   logic              mem_req_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [3:0]        mem_be_q;
   logic [31:0]       mem_wdata_q;

   logic              ls_win_d, if_win_d, mis_d;
   logic [ADDR_W-1:0] addr_d;
   logic [3:0]        be_d;
   logic [31:0]       wdata_d, rdata_d, shifted_d;

   // Load/store has priority except when fetch has been starved for a full streak.
   always_comb begin
      ls_win_d = bus.ls_req && !(bus.if_req && streak_q == STREAK_MAX);
      if_win_d = bus.if_req && !ls_win_d;
      addr_d   = ls_win_d ? bus.ls_addr : bus.if_addr;
      mis_d    = 1'b0;
      be_d     = 4'hF;
      wdata_d  = bus.ls_wdata;
      if (ls_win_d) begin
         case (bus.ls_size)
            2'd0: begin
               be_d    = 4'b0001 << bus.ls_addr[1:0];
               wdata_d = {4{bus.ls_wdata[7:0]}};
            end
            2'd1: begin
               mis_d   = bus.ls_addr[0];
               be_d    = bus.ls_addr[1] ? 4'b1100 : 4'b0011;
               wdata_d = {2{bus.ls_wdata[15:0]}};
            end
            2'd2:    mis_d = (bus.ls_addr[1:0] != 2'b00);
            default: mis_d = 1'b1;
         endcase
      end else begin
         mis_d = (bus.if_addr[1:0] != 2'b00);
      end
   end

   always_comb begin
      shifted_d = bus.mem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'd0:    rdata_d = {24'h0, shifted_d[7:0]};
         2'd1:    rdata_d = {16'h0, shifted_d[15:0]};
         default: rdata_d = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         tmo_q       <= '0;
         streak_q    <= '0;
         owner_ls_q  <= 1'b0;
         size_q      <= 2'd0;
         off_q       <= 2'd0;
         if_gnt_q    <= 1'b0;
         if_valid_q  <= 1'b0;
         if_err_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         ls_valid_q  <= 1'b0;
         ls_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= 4'h0;
         mem_wdata_q <= '0;
      end else begin
         if_gnt_q   <= 1'b0;
         ls_gnt_q   <= 1'b0;
         if_valid_q <= 1'b0;
         if_err_q   <= 1'b0;
         ls_valid_q <= 1'b0;
         ls_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.if_req && ls_win_d) streak_q <= streak_q + 1'b1;
               else                        streak_q <= '0;
               if (ls_win_d || if_win_d) begin
                  owner_ls_q <= ls_win_d;
                  size_q     <= ls_win_d ? bus.ls_size : 2'd2;
                  off_q      <= addr_d[1:0];
                  ls_gnt_q   <= ls_win_d;
                  if_gnt_q   <= if_win_d;
                  if (mis_d) begin
                     ls_err_q <= ls_win_d;
                     if_err_q <= if_win_d;
                     state_q  <= RESP;
                  end else begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= ls_win_d && bus.ls_we;
                     mem_addr_q  <= {addr_d[ADDR_W-1:2], 2'b00};
                     mem_be_q    <= be_d;
                     mem_wdata_q <= (ls_win_d && bus.ls_we) ? wdata_d : 32'h0;
                     tmo_q       <= TW'(1);
                     state_q     <= BUS;
                  end
               end
            end
            BUS: begin
               // An ack on the final allowed cycle still completes normally.
               if (bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  tmo_q     <= '0;
                  if (owner_ls_q) begin
                     ls_valid_q <= 1'b1;
                     ls_rdata_q <= rdata_d;
                  end else begin
                     if_valid_q <= 1'b1;
                     if_rdata_q <= bus.mem_rdata;
                  end
                  state_q <= RESP;
               end else if (tmo_q == TMO_MAX) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  tmo_q     <= '0;
                  ls_err_q  <= owner_ls_q;
                  if_err_q  <= !owner_ls_q;
                  state_q   <= RESP;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_err    = if_err_q;
   assign bus.ls_gnt    = ls_gnt_q;
   assign bus.ls_rdata  = ls_rdata_q;
   assign bus.ls_valid  = ls_valid_q;
   assign bus.ls_err    = ls_err_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares the CPU's single memory port between the instruction-fetch path (decode state) and the load/store path (load/store execute states).
- Arbitrates between the two requesters and sequences each transaction through a req/ack memory handshake.
- Generates byte enables, lane-aligns data, and flags misaligned or timed-out accesses.
- Sits between the Cpu core and the external bus; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- TIMEOUT, 255, maximum cycles in BUS waiting for mem_ack before an error response; must be ≥1.
- LS_STREAK_MAX, 4, consecutive load/store grants allowed while if_req is pending before fetch is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_valid or if_err.
- if_addr  in  ADDR_W  fetch address; word aligned.
- if_gnt  out  1  one-cycle pulse: fetch captured.
- if_rdata  out  32  fetched word; valid only while if_valid.
- if_valid  out  1  one-cycle pulse: fetch complete.
- if_err  out  1  one-cycle pulse: fetch misaligned or timed out.
- ls_req  in  1  load/store request; same holding rule as if_req.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- ls_addr  in  ADDR_W  byte address.
- ls_wdata  in  32  store data, LSB-justified.
- ls_gnt, ls_rdata (32), ls_valid, ls_err  out  as the fetch equivalents; ls_rdata is zero-extended and LSB-justified.
- mem_req  out  1  held high until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address; bits [1:0] forced to 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, sampled on mem_ack.
- mem_ack  in  1  transaction complete this cycle.

Behaviour:
- Reset: every output 0, state IDLE, timeout and streak counters 0. Reset asserted mid-transaction drops mem_req immediately; no response is issued to the requester.
- All outputs are registered.
- States:
  - IDLE: sample requests; if a winner is picked, capture its request and go to BUS, or to RESP with err if it fails the alignment check.
  - BUS: mem_req=1. On mem_ack, latch data and go to RESP. If the timeout counter reaches TIMEOUT, drop mem_req and go to RESP with err.
  - RESP: pulse the winner's valid or err for one cycle, then go to IDLE.
- Arbitration (IDLE only):
  - ls beats if, unless if_req is high and the streak counter equals LS_STREAK_MAX; then fetch wins.
  - Streak counter increments on each ls grant made while if_req is high.
  - Streak counter clears on an if grant, or when if_req is low at arbitration.
- gnt timing: gnt pulses in the first BUS cycle, coincident with the first mem_req, or in the RESP cycle for a misaligned access. After gnt, the granted requester's req is ignored until its response.
- A req withdrawn before gnt is treated as never issued.
- Latency: req sampled at edge N → mem_req high in cycle N+1. mem_ack in cycle N+1 → valid in cycle N+2 → IDLE in cycle N+3. Minimum 3 cycles per transaction.
- Alignment errors (no memory cycle; err in the cycle after sampling):
  - fetch: addr[1:0] ≠ 0.
  - half: addr[0] = 1.
  - word: addr[1:0] ≠ 0.
  - size = 3.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 or 4'b1100, selected by addr[1].
  - word: 4'b1111.
  - mem_be is driven for fetches (always 4'b1111) and loads as well as stores.
- Store data: byte lane replicated ×4; half replicated ×2; word as-is.
- Load data: selected lane shifted to LSB and zero-extended.
- Timeout counter:
  - Starts at 1 on the first BUS cycle.
  - If mem_ack arrives in the same cycle the counter hits TIMEOUT, the ack wins and the response is a normal valid.
- mem_ack outside BUS is ignored.

Test Plan:
- Fetch at 0x100 with mem_ack in the first BUS cycle, mem_rdata=0xDEADBEEF → if_gnt at N+1, if_valid at N+2, if_rdata=0xDEADBEEF, mem_be=4'hF.
- Simultaneous if_req/ls_req held continuously, with an ls_req re-asserted each time → grant order ls ×4, then if, then ls again; streak counter reset observed.
- Store byte 0xA5 to 0x203 → mem_addr=0x200, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1.
- Load half from 0x206 with mem_rdata=0x1234ABCD → ls_rdata=0x00001234.
- Load word from 0x101 → ls_err pulse, no mem_req ever asserted.
- Timeout: mem_ack never arrives, TIMEOUT=8 → mem_req high exactly 8 cycles then ls_err.
- Timeout tie: mem_ack arrives in the 8th BUS cycle → ls_valid, not ls_err.
- Reset mid-operation: rst asserted mid-BUS → mem_req low within the same cycle, no valid/err emitted, and the next request is arbitrated cleanly after rst deasserts.
